fll_loop_controller: RTL and testbench
======================================

// Module: fll_loop_controller
// PURPOSE
//  Sequences the carrier-frequency-offset loop. Consumes the filtered band-edge error stream,
//  integrates it into a signed NCO frequency word with a state-scheduled gain (wide ACQUIRE,
//  narrow TRACK), detects lock/loss-of-lock, supports freeze, and hands each word to the NCO
//  over a valid/ready handshake.
// PARAMETERS
//  ErrorLengthBits  12       width of signed error input
//  FreqWordBits     24       width of signed frequency word
//  AcquireShift     2        arithmetic right shift applied to error in ACQUIRE
//  TrackShift       6        arithmetic right shift applied to error in TRACK (> AcquireShift)
//  LockThreshold    64       |err| <= this counts as "in lock"
//  LockCount        32       consecutive in-lock samples for ACQUIRE->TRACK
//  UnlockCount      8        consecutive out-of-lock samples for TRACK->ACQUIRE
//  FreqLimit        4194303  symmetric saturation bound, word clamped to [-FreqLimit, +FreqLimit]
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset, synchronous, active-high
//  enable     in   1                 loop enable; low forces IDLE
//  freeze     in   1                 hold word while in TRACK
//  err        in   ErrorLengthBits   signed loop-filter error
//  err_valid  in   1                 err qualifier
//  err_ready  out  1                 controller can accept err
//  freq_word  out  FreqWordBits      signed NCO frequency word
//  freq_valid out  1                 freq_word update pending
//  freq_ready in   1                 NCO accepts update
//  locked     out  1                 high in TRACK and HOLD
//  state      out  2                 current state_e (debug)
// BEHAVIOUR
//  - Reset: state=IDLE, freq_word=0, freq_valid=0, locked=0, both counters=0. err_ready
//    follows its rule below: it is combinational, so it is 1 out of reset.
//  - err_ready = !freq_valid || freq_ready (one-deep output register). Accept = err_valid && err_ready.
//  - States: IDLE, ACQUIRE, TRACK, HOLD.
//     IDLE:    accepts and discards err. enable=1 -> ACQUIRE next cycle.
//     ACQUIRE: on accept, word update with AcquireShift. freeze is ignored.
//     TRACK:   on accept, word update with TrackShift. freeze=1 -> HOLD.
//     HOLD:    accepts and discards err. Word and both counters frozen. freeze=0 -> TRACK.
//  - enable=0 in any non-IDLE state -> IDLE; has priority over freeze and lock events.
//     On that transition: freq_word<=0, freq_valid<=1 (NCO zeroed), counters cleared, locked<=0.
//  - Word update: sum = freq_word + (sign-extended err >>> shift), computed at FreqWordBits+1.
//     Then clamp to +/-FreqLimit. The shift floors toward -inf (err=-1 >>> k yields -1).
//  - Update timing: freq_word registered and freq_valid=1 on the cycle after accept (latency 1).
//     freq_valid holds with freq_word stable until freq_ready. freq_valid clears on handshake
//     unless a new accept occurs the same cycle (back-to-back: one word/cycle).
//  - Lock metric: |err| computed at ErrorLengthBits+1, so -2^(N-1) is handled without overflow.
//  - ACQUIRE: in-lock increments in_cnt, out-of-lock clears it. in_cnt==LockCount-1 plus an
//     in-lock accept -> TRACK, locked<=1, counters cleared.
//  - TRACK: out-of-lock increments out_cnt, in-lock clears it. out_cnt==UnlockCount-1 plus an
//     out-of-lock accept -> ACQUIRE, locked<=0, counters cleared.
//     That same sample still updates the word with TrackShift.
//  - Counters change only on accepted samples; err_valid gaps hold them.
//  - rst mid-operation: returns to reset values next edge; any pending update is dropped.
// STRUCTURE
//  - fll_pkg: typedef enum logic [1:0] state_e {IDLE, ACQUIRE, TRACK, HOLD}.
//  - fll_pkg also holds the saturating add function sat_add.
//  - Sub-module fll_lock_detector: abs/threshold compare, in/out counters, lock/unlock pulses.
//  - Top: FSM, gain mux, saturating integrator, output handshake register.
// TESTING
//  - Defaults, enable=1, err=400 one beat, freq_ready=1 -> ACQUIRE, freq_word=100, one freq_valid pulse.
//  - err=10 x32 in ACQUIRE -> locked rises after 32nd accept, state=TRACK.
//    Then err=640 -> word += 10 (TrackShift=6).
//  - In TRACK, err=100 x8 -> after 8th accept state=ACQUIRE, locked=0.
//    In-lock sample at beat 5 restarts the count (needs 8 more).
//  - FreqLimit=1000, err=2047 repeated in ACQUIRE -> word climbs by 511, then sticks at 1000.
//    err=-2048 repeated -> word sticks at -1000.
//  - freq_ready=0 for 5 cycles with err_valid=1 -> err_ready=0, freq_word stable, no samples lost.
//  - freeze=1 in TRACK -> HOLD, word constant under err=500 traffic.
//    enable=0 during HOLD -> IDLE, freq_word=0 with freq_valid=1.

Source files
------------

// File: rtl/fll_pkg.sv
// FLL loop controller shared types: loop state encoding
// and the saturating adder used by the frequency integrator.
package fll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Wide enough for any word/error width in use here,
  // so the add itself never wraps before the clamp.
  localparam int SatBits = 48;

  typedef logic signed [SatBits-1:0] sat_t;

  function automatic sat_t sat_add(
    input sat_t a,
    input sat_t b,
    input sat_t lim
  );
    sat_t s;
    s = a + b;
    if (s > lim)
      sat_add = lim;
    else if (s < -lim)
      sat_add = -lim;
    else
      sat_add = s;
  endfunction

endpackage

// File: rtl/fll_loop_controller_if.sv
// Error-in / frequency-out valid-ready bundle of the FLL controller.
// master: controller side; slave: error source and NCO side.
interface fll_loop_controller_if #(
  parameter int ErrorLengthBits = 12,
  parameter int FreqWordBits    = 24
);

  logic signed [ErrorLengthBits-1:0] err;
  logic                              err_valid;
  logic                              err_ready;
  logic signed [FreqWordBits-1:0]    freq_word;
  logic                              freq_valid;
  logic                              freq_ready;

  modport master (
    input  err,
    input  err_valid,
    input  freq_ready,
    output err_ready,
    output freq_word,
    output freq_valid
  );

  modport slave (
    output err,
    output err_valid,
    output freq_ready,
    input  err_ready,
    input  freq_word,
    input  freq_valid
  );

endinterface

// File: rtl/fll_lock_detector.sv
// Lock metric: |err| threshold, in/out-of-lock run counters, lock/unlock hits.
// Ports: clk, rst, err, accept, mode, clear -> lock_hit, unlock_hit.
module fll_lock_detector
  import fll_pkg::*;
#(
  parameter int ErrorLengthBits = 12,
  parameter int LockThreshold   = 64,
  parameter int LockCount       = 32,
  parameter int UnlockCount     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [ErrorLengthBits-1:0] err,
  input  logic                              accept,
  input  state_e                            mode,
  input  logic                              clear,
  output logic                              lock_hit,
  output logic                              unlock_hit
);

  localparam int IW = $clog2(LockCount + 1);
  localparam int OW = $clog2(UnlockCount + 1);
  localparam int MW = ErrorLengthBits + 1;

  logic [MW-1:0] ext;
  logic [MW-1:0] mag;
  logic          in_lock;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;

  // One extra bit so the most negative error has a magnitude.
  always_comb begin
    ext = {err[ErrorLengthBits-1], err};
    mag = ext[MW-1] ? (~ext) + MW'(1) : ext;
  end

  assign in_lock = mag <= MW'(LockThreshold);

  assign lock_hit = accept && (mode == ACQUIRE) && in_lock
                 && (in_cnt == IW'(LockCount - 1));

  assign unlock_hit = accept && (mode == TRACK) && !in_lock
                   && (out_cnt == OW'(UnlockCount - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (accept) begin
      unique case (mode)
        ACQUIRE: begin
          if (lock_hit) begin
            in_cnt  <= '0;
            out_cnt <= '0;
          end else if (in_lock) begin
            in_cnt <= in_cnt + IW'(1);
          end else begin
            in_cnt <= '0;
          end
        end
        TRACK: begin
          if (unlock_hit) begin
            in_cnt  <= '0;
            out_cnt <= '0;
          end else if (!in_lock) begin
            out_cnt <= out_cnt + OW'(1);
          end else begin
            out_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fll_loop_controller.sv
// FLL loop sequencer: FSM, gain mux, saturating integrator, NCO output register.
// Ports: clk, rst, enable, freeze, bus (err in / freq_word out), locked, state.
module fll_loop_controller
  import fll_pkg::*;
#(
  parameter int ErrorLengthBits = 12,
  parameter int FreqWordBits    = 24,
  parameter int AcquireShift    = 2,
  parameter int TrackShift      = 6,
  parameter int LockThreshold   = 64,
  parameter int LockCount       = 32,
  parameter int UnlockCount     = 8,
  parameter int FreqLimit       = 4194303
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  freeze,
  fll_loop_controller_if.master bus,
  output logic                  locked,
  output logic [1:0]            state
);

  state_e                         state_q;
  state_e                         state_d;
  logic signed [FreqWordBits-1:0] word_q;
  logic signed [FreqWordBits-1:0] word_d;
  logic                           valid_q;
  logic                           rdy;
  logic                           accept;
  logic                           upd;
  logic                           kill;
  logic                           clear;
  logic                           lock_hit;
  logic                           unlock_hit;
  sat_t                           err_w;
  sat_t                           step_w;
  sat_t                           sum_w;

  // One-deep output register: a new sample is taken only
  // when the previous word is gone or leaves this cycle.
  assign rdy    = !valid_q || bus.freq_ready;
  assign accept = bus.err_valid && rdy;

  assign kill  = !enable && (state_q != IDLE);
  assign clear = !enable || (state_q == IDLE);
  assign upd   = accept && enable
              && ((state_q == ACQUIRE) || (state_q == TRACK));

  fll_lock_detector #(
    .ErrorLengthBits (ErrorLengthBits),
    .LockThreshold   (LockThreshold),
    .LockCount       (LockCount),
    .UnlockCount     (UnlockCount)
  ) u_lock (
    .clk        (clk),
    .rst        (rst),
    .err        (bus.err),
    .accept     (accept),
    .mode       (state_q),
    .clear      (clear),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  // Arithmetic shift floors toward -inf, so -1 stays -1.
  always_comb begin
    err_w  = SatBits'(bus.err);
    step_w = (state_q == TRACK) ? (err_w >>> TrackShift)
                                : (err_w >>> AcquireShift);
    sum_w  = sat_add(SatBits'(word_q), step_w, SatBits'(FreqLimit));
    word_d = FreqWordBits'(sum_w);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable)
          state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (!enable)
          state_d = IDLE;
        else if (lock_hit)
          state_d = TRACK;
      end
      TRACK: begin
        if (!enable)
          state_d = IDLE;
        else if (unlock_hit)
          state_d = ACQUIRE;
        else if (freeze)
          state_d = HOLD;
      end
      HOLD: begin
        if (!enable)
          state_d = IDLE;
        else if (!freeze)
          state_d = TRACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Leaving the loop pushes a zero word so the NCO recentres.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (kill) begin
      word_q  <= '0;
      valid_q <= 1'b1;
    end else if (upd) begin
      word_q  <= word_d;
      valid_q <= 1'b1;
    end else if (bus.freq_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.err_ready  = rdy;
  assign bus.freq_word  = word_q;
  assign bus.freq_valid = valid_q;
  assign locked = (state_q == TRACK) || (state_q == HOLD);
  assign state  = state_q;

endmodule

// File: tb/tb_fll_loop_controller.sv
// Directed bench: two lockstep controllers (default and FreqLimit=1000)
// driven from a vector table plus hand-written lock/freeze/saturation runs.
module tb_fll_loop_controller;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic freeze;
  logic err_valid;
  logic freq_ready;
  logic signed [11:0] err;

  logic       locked_a;
  logic       locked_b;
  logic [1:0] state_a;
  logic [1:0] state_b;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int en;
    int fz;
    int ev;
    int fr;
    int e;
    int w;
    int v;
    int st;
    int lk;
    int rdy;
  } vec_t;

  vec_t tbl[13];
  int   bexp[8];
  int   aexp[8];

  always #5 clk = ~clk;

  fll_loop_controller_if #(.ErrorLengthBits(12), .FreqWordBits(24)) ia ();
  fll_loop_controller_if #(.ErrorLengthBits(12), .FreqWordBits(24)) ib ();

  assign ia.err        = err;
  assign ia.err_valid  = err_valid;
  assign ia.freq_ready = freq_ready;
  assign ib.err        = err;
  assign ib.err_valid  = err_valid;
  assign ib.freq_ready = freq_ready;

  fll_loop_controller dut_a (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .freeze (freeze),
    .bus    (ia.master),
    .locked (locked_a),
    .state  (state_a)
  );

  fll_loop_controller #(.FreqLimit(1000)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .freeze (freeze),
    .bus    (ib.master),
    .locked (locked_b),
    .state  (state_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int en, input int fz, input int ev,
                      input int fr, input int e);
    enable     = (en != 0);
    freeze     = (fz != 0);
    err_valid  = (ev != 0);
    freq_ready = (fr != 0);
    err        = 12'(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int w, input int v,
                       input int st, input int lk, input int rdy);
    chk({tag, " word"}, longint'(ia.freq_word), w);
    chk({tag, " valid"}, longint'(ia.freq_valid), v);
    chk({tag, " state"}, longint'(state_a), st);
    chk({tag, " locked"}, longint'(locked_a), lk);
    chk({tag, " err_ready"}, longint'(ia.err_ready), rdy);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 1,    0,   0, 0, 1, 0, 1};
    tbl[1]  = '{1, 0, 1, 1,  400, 100, 1, 1, 0, 1};
    tbl[2]  = '{1, 0, 0, 1,    0, 100, 0, 1, 0, 1};
    tbl[3]  = '{1, 0, 1, 0,   40, 110, 1, 1, 0, 0};
    tbl[4]  = '{1, 0, 1, 0,   40, 110, 1, 1, 0, 0};
    tbl[5]  = '{1, 0, 1, 0,   40, 110, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 0,   40, 110, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 1, 0,   40, 110, 1, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 1,   40, 120, 1, 1, 0, 1};
    tbl[9]  = '{1, 0, 1, 1,  -40, 110, 1, 1, 0, 1};
    tbl[10] = '{1, 0, 1, 1,   -1, 109, 1, 1, 0, 1};
    tbl[11] = '{1, 0, 1, 1,  400, 209, 1, 1, 0, 1};
    tbl[12] = '{1, 0, 0, 1,    0, 209, 0, 1, 0, 1};

    bexp = '{511, 1000, 1000, 488, -24, -536, -1000, -1000};
    aexp = '{511, 1022, 1533, 1021, 509, -3, -515, -1027};

    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_a("reset", 0, 0, 0, 0, 1);
    chk("reset b word", longint'(ib.freq_word), 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].fz, tbl[i].ev, tbl[i].fr, tbl[i].e);
      chk_a($sformatf("vec%0d", i), tbl[i].w, tbl[i].v,
            tbl[i].st, tbl[i].lk, tbl[i].rdy);
      chk($sformatf("vec%0d b word", i), longint'(ib.freq_word), tbl[i].w);
    end

    for (int i = 0; i < 31; i++)
      step(1, 0, 1, 1, 10);
    chk_a("acq31", 271, 1, 1, 0, 1);
    step(1, 0, 1, 1, 10);
    chk_a("acq32", 273, 1, 2, 1, 1);

    step(1, 0, 1, 1, 640);
    chk_a("track640", 283, 1, 2, 1, 1);
    step(1, 0, 1, 1, 0);

    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 1, 100);
    step(1, 0, 1, 1, 10);
    chk_a("unl restart", 287, 1, 2, 1, 1);
    for (int i = 0; i < 7; i++)
      step(1, 0, 1, 1, 100);
    chk_a("unl7", 294, 1, 2, 1, 1);
    step(1, 0, 1, 1, 100);
    chk_a("unl8", 295, 1, 1, 0, 1);

    for (int i = 0; i < 32; i++)
      step(1, 0, 1, 1, 0);
    chk_a("relock", 295, 1, 2, 1, 1);

    step(1, 1, 0, 1, 0);
    chk_a("hold", 295, 0, 3, 1, 1);
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 1, 500);
    chk_a("hold traffic", 295, 0, 3, 1, 1);
    step(1, 0, 0, 1, 0);
    chk("unfreeze state", longint'(state_a), 2);
    step(1, 1, 0, 1, 0);
    chk("refreeze state", longint'(state_a), 3);

    step(0, 1, 0, 0, 0);
    chk_a("disable hold", 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk_a("nco ack", 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 300);
    chk_a("idle discard", 0, 0, 0, 0, 1);

    step(1, 0, 0, 1, 0);
    chk("sat enter", longint'(state_b), 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 1, (i < 3) ? 2047 : -2048);
      chk($sformatf("sat b %0d", i), longint'(ib.freq_word), bexp[i]);
      chk($sformatf("sat a %0d", i), longint'(ia.freq_word), aexp[i]);
    end
    chk("sat b state", longint'(state_b), 1);

    rst = 1'b1;
    step(1, 0, 1, 1, 400);
    rst = 1'b0;
    chk_a("mid rst", 0, 0, 0, 0, 1);
    chk("mid rst b word", longint'(ib.freq_word), 0);
    step(1, 0, 0, 1, 0);
    chk("post rst state", longint'(state_a), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
